// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit buffer.
// Sequencer state encoding, default sizes, byte width.
package uart_pkg;

   localparam int BYTE_W = 8;

   localparam int DEFAULT_DEPTH        = 8;
   localparam int DEFAULT_BUSY_TIMEOUT = 16;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_LOAD      = 2'd1;
   localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
   localparam logic [1:0] ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Write handshake between the buffer and uart_transmitter.
// master = buffer side, slave = transmitter side.
interface uart_tx_buffer_if;
   import uart_pkg::*;

   logic [BYTE_W-1:0] Tx_DATA;
   logic              Tx_WR;
   logic              Tx_EN;
   logic              Tx_BUSY;

   modport master (
      output Tx_DATA,
      output Tx_WR,
      output Tx_EN,
      input  Tx_BUSY
   );

   modport slave (
      input  Tx_DATA,
      input  Tx_WR,
      input  Tx_EN,
      output Tx_BUSY
   );

endinterface

// File: rtl/uart_tx_fifo_mem.sv
// Byte storage for the transmit FIFO.
// One write port, combinational read; array is not reset.
module uart_tx_fifo_mem
   import uart_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] wptr,
   input  logic [BYTE_W-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0] rptr,
   output logic [BYTE_W-1:0]        rdata
);

   logic [BYTE_W-1:0] mem_q [DEPTH];

   // store the pushed byte at the write pointer
   always_ff @(posedge clk) begin
      if (we) mem_q[wptr] <= wdata;
   end

   assign rdata = mem_q[rptr];

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus write sequencer feeding uart_transmitter.
// UART_TX_BUF_OVERFLOW_STICKY_EN: overflow holds until reset.
module uart_tx_buffer
   import uart_pkg::*;
#(
   parameter int DEPTH        = DEFAULT_DEPTH,
   parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [BYTE_W-1:0]      wr_data,
   input  logic                   tx_enable,
   uart_tx_buffer_if.master       tx,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(BUSY_TIMEOUT) + 1;

   logic [AW-1:0]     wptr_q, wptr_d;
   logic [AW-1:0]     rptr_q, rptr_d;
   logic [AW:0]       level_q, level_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              ovf_q, ovf_d;
   logic [1:0]        state_q, state_d;
   logic [TW-1:0]     tout_q, tout_d;
   logic [BYTE_W-1:0] tx_data_q, tx_data_d;
   logic [BYTE_W-1:0] head;
   logic              push, pop, drop;

   uart_tx_fifo_mem #(.DEPTH(DEPTH)) u_mem (
      .clk   (clk),
      .we    (push),
      .wptr  (wptr_q),
      .wdata (wr_data),
      .rptr  (rptr_q),
      .rdata (head)
   );

   // FIFO bookkeeping: a pop frees a slot for a same-cycle push
   always_comb begin
      pop  = (state_q == ST_IDLE) && !empty_q
             && tx_enable && !tx.Tx_BUSY;
      push = wr_en && (!full_q || pop);
      drop = wr_en && full_q && !pop;
      wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
      level_d = level_q;
      if (push && !pop) level_d = level_q + (AW+1)'(1);
      if (pop && !push) level_d = level_q - (AW+1)'(1);
      full_d  = (level_d == (AW+1)'(DEPTH));
      empty_d = (level_d == '0);
`ifdef UART_TX_BUF_OVERFLOW_STICKY_EN
      ovf_d = ovf_q | drop;
`else
      ovf_d = drop;
`endif
   end

   // launch sequencer: load, strobe, wait for busy, wait for done
   always_comb begin
      state_d   = state_q;
      tout_d    = tout_q;
      tx_data_d = tx_data_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pop) begin
               tx_data_d = head;
               state_d   = ST_LOAD;
            end
         end
         ST_LOAD: begin
            tout_d  = '0;
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (tx.Tx_BUSY) begin
               state_d = ST_WAIT_DONE;
            end else if (tout_q == TW'(BUSY_TIMEOUT - 1)) begin
               state_d = ST_IDLE;
            end else begin
               tout_d = tout_q + TW'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (!tx.Tx_BUSY) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state registers; reset discards queued bytes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         level_q   <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         ovf_q     <= 1'b0;
         state_q   <= ST_IDLE;
         tout_q    <= '0;
         tx_data_q <= '0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         level_q   <= level_d;
         full_q    <= full_d;
         empty_q   <= empty_d;
         ovf_q     <= ovf_d;
         state_q   <= state_d;
         tout_q    <= tout_d;
         tx_data_q <= tx_data_d;
      end
   end

   assign tx.Tx_DATA = tx_data_q;
   assign tx.Tx_WR   = (state_q == ST_LOAD);
   assign tx.Tx_EN   = tx_enable;
   assign full       = full_q;
   assign empty      = empty_q;
   assign level      = level_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed self-checking bench for uart_tx_buffer.
// Includes a simple transmitter busy model.
module tb_uart_tx_buffer;
   import uart_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       tx_enable = 1'b0;
   logic       full, empty, overflow;
   logic [3:0] level;

   uart_tx_buffer_if bus ();

   uart_tx_buffer #(.DEPTH(8), .BUSY_TIMEOUT(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .tx_enable (tx_enable),
      .tx        (bus),
      .full      (full),
      .empty     (empty),
      .level     (level),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;

   logic model_on = 1'b1;
   int   busy_len = 20;
   int   busy_cnt = 0;

   logic [7:0] pq_data [$];
   int         pq_cyc  [$];
   logic       pq_busy [$];

   assign bus.Tx_BUSY = (busy_cnt != 0);

   always @(posedge clk) cyc <= cyc + 1;

   // transmitter model: busy rises the cycle after Tx_WR
   always @(posedge clk) begin
      if (bus.Tx_WR && model_on) busy_cnt <= busy_len;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end

   // record every write strobe
   always @(negedge clk) begin
      if (bus.Tx_WR) begin
         pq_data.push_back(bus.Tx_DATA);
         pq_cyc.push_back(cyc);
         pq_busy.push_back(bus.Tx_BUSY);
      end
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_pulses(input int n, input int budget);
      int k = 0;
      while (pq_data.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("pulse_wait", pq_data.size(), n);
   endtask

   task automatic clr_q();
      pq_data.delete();
      pq_cyc.delete();
      pq_busy.delete();
   endtask

   // fill with base..base+n-1 while launches are blocked
   task automatic fill(input logic [7:0] base, input int n);
      tx_enable = 1'b0;
      for (int i = 0; i < n; i++) begin
         wr_en   = 1'b1;
         wr_data = base + 8'(i);
         @(negedge clk);
      end
      wr_en = 1'b0;
   endtask

   initial begin
      int base;
      // reset state
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_level", level, 0);
      check("rst_wr", bus.Tx_WR, 0);
      check("rst_data", bus.Tx_DATA, 8'h00);
      check("rst_ovf", overflow, 0);

      // single byte: Tx_WR two edges after the push
      tx_enable = 1'b1;
      wr_en = 1'b1;
      wr_data = 8'hA5;
      @(negedge clk);
      wr_en = 1'b0;
      check("s_level1", level, 1);
      check("s_wr_early", bus.Tx_WR, 0);
      @(negedge clk);
      check("s_wr", bus.Tx_WR, 1);
      check("s_data", bus.Tx_DATA, 8'hA5);
      check("s_empty", empty, 1);
      @(negedge clk);
      check("s_wr_1cyc", bus.Tx_WR, 0);
      repeat (30) @(negedge clk);
      check("s_count", pq_data.size(), 1);
      check("s_hold", bus.Tx_DATA, 8'hA5);
      clr_q();

      // burst 01..08 fills the buffer, then drains in order
      fill(8'h01, 8);
      check("b_full", full, 1);
      check("b_level", level, 8);
      tx_enable = 1'b1;
      wait_pulses(8, 400);
      for (int i = 0; i < 8; i++) begin
         if (i < pq_data.size()) begin
            check($sformatf("b_data%0d", i), pq_data[i], i + 1);
            check($sformatf("b_busy%0d", i), pq_busy[i], 0);
            if (i > 0)
               check($sformatf("b_gap%0d", i),
                     pq_cyc[i] - pq_cyc[i-1], 23);
         end
      end
      repeat (30) @(negedge clk);
      check("b_empty", empty, 1);
      clr_q();

      // overflow: push FF into a full buffer
      fill(8'h10, 8);
      wr_en = 1'b1;
      wr_data = 8'hFF;
      @(negedge clk);
      wr_en = 1'b0;
      check("o_level", level, 8);
      check("o_ovf", overflow, 1);
      @(negedge clk);
`ifdef UART_TX_BUF_OVERFLOW_STICKY_EN
      check("o_ovf_after", overflow, 1);
`else
      check("o_ovf_after", overflow, 0);
`endif
      tx_enable = 1'b1;
      wait_pulses(8, 400);
      if (pq_data.size() == 8) begin
         check("o_first", pq_data[0], 8'h10);
         check("o_last", pq_data[7], 8'h17);
      end
      repeat (30) @(negedge clk);
      check("o_nodrop", pq_data.size(), 8);
      clr_q();

      // timeout: busy never rises
      model_on = 1'b0;
      fill(8'h30, 2);
      tx_enable = 1'b1;
      wait_pulses(2, 100);
      if (pq_data.size() == 2) begin
         check("t_gap", pq_cyc[1] - pq_cyc[0], 18);
         check("t_data0", pq_data[0], 8'h30);
         check("t_data1", pq_data[1], 8'h31);
      end
      repeat (25) @(negedge clk);
      check("t_count", pq_data.size(), 2);
      check("t_empty", empty, 1);
      clr_q();

      // reset while waiting for the transmitter to finish
      model_on = 1'b1;
      fill(8'h40, 4);
      tx_enable = 1'b1;
      wait_pulses(1, 20);
      repeat (5) @(negedge clk);
      check("r_level_pre", level, 3);
      reset = 1'b0;
      @(negedge clk);
      check("r_level_in", level, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("r_level", level, 0);
      check("r_empty", empty, 1);
      check("r_ovf", overflow, 0);
      repeat (40) @(negedge clk);
      check("r_no_wr", pq_data.size(), 1);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Byte queue and write sequencer placed directly upstream of `uart_transmitter`. Producers push bytes at clock rate; the block stores up to DEPTH bytes and launches them one at a time through the transmitter's `Tx_DATA`/`Tx_WR`/`Tx_BUSY` handshake. The `data` stimulus block is replaced with a buffered source, so bursts of bytes are serialised without loss.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2 to 64.
- `BUSY_TIMEOUT`, 16: cycles to wait for `Tx_BUSY` to rise after a `Tx_WR` pulse.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `wr_en` in 1: push request for `wr_data`.
- `wr_data` in 8: byte to enqueue.
- `tx_enable` in 1: permits launching new bytes; also drives the transmitter's `Tx_EN`.
- `Tx_BUSY` in 1: transmitter busy, from `uart_transmitter`.
- `Tx_DATA` out 8: byte presented to the transmitter.
- `Tx_WR` out 1: one-cycle write strobe to the transmitter.
- `Tx_EN` out 1: equals `tx_enable`, combinational.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `level` out clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: write dropped; see Configuration.

## Operation
- FIFO
  - Read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
  - `level` is a separate counter.
- Push
  - A push is accepted when `wr_en`=1 and (`full`=0 or a pop occurs in the same cycle).
  - A push with `full`=1 and no pop is dropped and raises `overflow`.
  - Push and pop in the same cycle leave `level` unchanged.
- Pop: happens only on the IDLE→LOAD transition.
- Sequencer states and transitions:
  - IDLE: if `empty`=0, `tx_enable`=1 and `Tx_BUSY`=0, register the head byte into `Tx_DATA`, pop, and go to LOAD.
  - LOAD: `Tx_WR`=1 for exactly this cycle; go to WAIT_BUSY and clear the timeout counter.
  - WAIT_BUSY:
    - `Tx_BUSY`=1 → WAIT_DONE.
    - Otherwise increment the counter.
    - At BUSY_TIMEOUT−1 → IDLE; the byte is treated as consumed and not retried.
  - WAIT_DONE: `Tx_BUSY`=0 → IDLE.
- `Tx_DATA` holds its value from LOAD until the next LOAD.
- `tx_enable` deasserting outside IDLE does not abort the byte in flight. It only blocks the next launch.
- Reset mid-operation:
  - FIFO contents are discarded: pointers and `level` go to 0.
  - The state goes to IDLE.
  - Any transmission already started in the transmitter is not tracked.

## Timing
- Reset values:
  - `Tx_DATA`=8'h00, `Tx_WR`=0, `full`=0, `empty`=1, `level`=0, `overflow`=0.
  - State is IDLE, timeout counter is 0.
- `full`, `empty` and `level` are registered and update the cycle after the push or pop edge.
- Latency from the first push into an empty buffer to `Tx_WR`=1:
  - Edge 1: push.
  - Edge 2: IDLE sees `empty`=0 and loads → LOAD.
  - `Tx_WR` is high in the cycle after edge 2.
- Minimum spacing between consecutive `Tx_WR` pulses is 4 cycles (LOAD, WAIT_BUSY, WAIT_DONE, IDLE), plus the transmitter's busy time.
- Timeout path: `Tx_WR` is followed by BUSY_TIMEOUT cycles in WAIT_BUSY, then IDLE.

## Configuration
- `UART_TX_BUF_OVERFLOW_STICKY_EN`
  - Defined: `overflow` is sticky. It sets on the first dropped push and clears only on reset.
  - Undefined: `overflow` is a one-cycle registered pulse per dropped push.
- FIFO behaviour is identical in both cases.

## Structure
- Shared package `uart_pkg` holds:
  - The sequencer state encoding (IDLE, LOAD, WAIT_BUSY, WAIT_DONE, 2-bit).
  - Default DEPTH and BUSY_TIMEOUT constants.
  - The byte-width constant (8).
- One sub-module, `uart_tx_fifo_mem`:
  - Storage array with write port (wptr, wdata, we) and combinational read at rptr.
  - No reset on the array.
- Pointers, `level` and the sequencer live in `uart_tx_buffer`.

## Test plan
- Reset state: reset low, then released → `empty`=1, `level`=0, `Tx_WR`=0, `Tx_DATA`=8'h00.
- Single byte:
  - Stimulus: push 8'hA5 with `tx_enable`=1, transmitter model raises `Tx_BUSY` 1 cycle after `Tx_WR` and holds it 20 cycles.
  - Response: exactly one `Tx_WR` pulse 2 cycles after the push, `Tx_DATA`=8'hA5, `empty`=1 afterwards.
- Burst: push 8'h01..8'h08 back-to-back (DEPTH=8) → `full`=1 after the 8th push; 8 `Tx_WR` pulses in order 01..08, each issued only after `Tx_BUSY` has fallen.
- Overflow:
  - Stimulus: fill to full with `tx_enable`=0, push 8'hFF.
  - Response: byte dropped, `level` stays 8, `overflow` high. With the macro, `overflow` stays high until reset; without it, high for 1 cycle.
- Timeout: transmitter model never raises `Tx_BUSY`, 2 bytes queued → second `Tx_WR` occurs 16 cycles after WAIT_BUSY entry plus 2.
- Reset mid-operation: assert reset during WAIT_DONE with 3 bytes queued → `level`=0 and no further `Tx_WR` after release.
